mips_instruction_fetch_buffer: RTL and testbench

- Decoupling FIFO between instruction fetch and decode in the pipelined MIPS core.
- Accepts fetched instruction words with their PCs through a valid/ready handshake and holds them in order.
- Presents the head entry to decode, pre-split into the R-format op field (bits 31:26) and func field (bits 5:0). Decode's op/func-to-opFunc mapping consumes those fields.
- A synchronous flush, driven by a taken branch or jump, discards all buffered entries.

---
 rtl/mips_instruction_fetch_buffer_if.sv | 32 +++
 rtl/mips_instruction_fetch_buffer.sv | 74 +++++++
 tb/tb_mips_instruction_fetch_buffer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_instruction_fetch_buffer_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch buffer.
// The slave side is the buffer; the master side is fetch plus decode.
interface mips_instruction_fetch_buffer_if #(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned INST_WIDTH = 32,
   parameter int unsigned PC_WIDTH   = 32
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic                  in_valid;
   logic                  in_ready;
   logic [INST_WIDTH-1:0] in_inst;
   logic [PC_WIDTH-1:0]   in_pc;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [INST_WIDTH-1:0] out_inst;
   logic [PC_WIDTH-1:0]   out_pc;
   logic [5:0]            out_op;
   logic [5:0]            out_func;
   logic [CNT_W-1:0]      count;

   modport master (
      output in_valid, in_inst, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_inst, out_pc, out_op, out_func, count
   );

   modport slave (
      input  in_valid, in_inst, in_pc, flush, out_ready,
      output in_ready, out_valid, out_inst, out_pc, out_op, out_func, count
   );
endinterface

// File: rtl/mips_instruction_fetch_buffer.sv
// In-order FIFO decoupling instruction fetch from decode; the head is shown
// pre-split into op/func fields and reads as a NOP (all zeros) when empty.
module mips_instruction_fetch_buffer #(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned INST_WIDTH = 32,
   parameter int unsigned PC_WIDTH   = 32
) (
   input logic                          clk,
   input logic                          rst_n,
   mips_instruction_fetch_buffer_if.slave fb
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [INST_WIDTH-1:0] inst_mem [DEPTH];
   logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];

   logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             not_empty, wr, rd;

   // Flags depend only on state and reset, never on out_ready.
   assign not_empty = (cnt != '0);
   assign fb.in_ready  = rst_n & (cnt < CNT_W'(DEPTH));
   assign fb.out_valid = not_empty;
   assign wr = fb.in_valid & fb.in_ready;
   assign rd = not_empty & fb.out_ready;

   assign fb.out_inst = not_empty ? inst_mem[rd_ptr] : '0;
   assign fb.out_pc   = not_empty ? pc_mem[rd_ptr]   : '0;
   assign fb.out_op   = fb.out_inst[31:26];
   assign fb.out_func = fb.out_inst[5:0];
   assign fb.count    = cnt;

   // Next-state for pointers and occupancy; flush wins over everything.
   always_comb begin
      rd_ptr_nxt = rd_ptr;
      wr_ptr_nxt = wr_ptr;
      cnt_nxt    = cnt;
      if (fb.flush) begin
         rd_ptr_nxt = '0;
         wr_ptr_nxt = '0;
         cnt_nxt    = '0;
      end else begin
         if (wr) wr_ptr_nxt = wr_ptr + PTR_W'(1);
         if (rd) rd_ptr_nxt = rd_ptr + PTR_W'(1);
         case ({wr, rd})
            2'b10:   cnt_nxt = cnt + CNT_W'(1);
            2'b01:   cnt_nxt = cnt - CNT_W'(1);
            default: cnt_nxt = cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         rd_ptr <= rd_ptr_nxt;
         wr_ptr <= wr_ptr_nxt;
         cnt    <= cnt_nxt;
      end
   end

   // Entry storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (wr && !fb.flush) begin
         inst_mem[wr_ptr] <= fb.in_inst;
         pc_mem[wr_ptr]   <= fb.in_pc;
      end
   end
endmodule

// File: tb/tb_mips_instruction_fetch_buffer.sv
// Randomized bench for the fetch buffer: a queue model is checked every cycle,
// with hand-computed expectations for the directed scenarios.
module tb_mips_instruction_fetch_buffer;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned IW    = 32;
   localparam int unsigned PW    = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mips_instruction_fetch_buffer_if #(.DEPTH(DEPTH), .INST_WIDTH(IW), .PC_WIDTH(PW)) bus();

   mips_instruction_fetch_buffer #(.DEPTH(DEPTH), .INST_WIDTH(IW), .PC_WIDTH(PW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fb    (bus)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t mq[$];
   int   checks = 0;
   int   errors = 0;
   bit   run    = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Queue model: transfers decided from pre-edge occupancy, flush empties it.
   always @(posedge clk or negedge rst_n) begin : model_upd
      bit w, r;
      if (!rst_n) begin
         mq.delete();
      end else begin
         w = bus.in_valid && (mq.size() < DEPTH);
         r = (mq.size() != 0) && bus.out_ready;
         if (r) void'(mq.pop_front());
         if (bus.flush) mq.delete();
         else if (w) mq.push_back('{bus.in_inst, bus.in_pc});
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin : compare
      logic [31:0] ei, ep;
      int n;
      if (run) begin
         n  = mq.size();
         ei = (n != 0) ? mq[0].inst : 32'h0;
         ep = (n != 0) ? mq[0].pc   : 32'h0;
         chk("cmp_in_ready",  64'(bus.in_ready),  64'(rst_n && (n < DEPTH)));
         chk("cmp_out_valid", 64'(bus.out_valid), 64'(n != 0));
         chk("cmp_count",     64'(bus.count),     64'(n));
         chk("cmp_out_inst",  64'(bus.out_inst),  64'(ei));
         chk("cmp_out_pc",    64'(bus.out_pc),    64'(ep));
         chk("cmp_out_op",    64'(bus.out_op),    64'(ei[31:26]));
         chk("cmp_out_func",  64'(bus.out_func),  64'(ei[5:0]));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [31:0] i, input logic [31:0] p,
                        input bit r, input bit f);
      bus.in_valid  = v;
      bus.in_inst   = i;
      bus.in_pc     = p;
      bus.out_ready = r;
      bus.flush     = f;
   endtask

   logic [31:0] words[16];
   logic [31:0] got[$];
   int          sent;
   bit          acc_w;

   initial begin
      drive(0, 32'h0, 32'h0, 0, 0);
      run = 1'b1;
      repeat (3) cyc();
      chk("rst_in_ready_low", 64'(bus.in_ready), 64'h0);
      #2 rst_n = 1'b1;
      cyc();
      chk("rst_in_ready",  64'(bus.in_ready),  64'h1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
      chk("rst_count",     64'(bus.count),     64'h0);
      chk("rst_out_inst",  64'(bus.out_inst),  64'h0);
      chk("rst_out_op",    64'(bus.out_op),    64'h0);
      chk("rst_out_func",  64'(bus.out_func),  64'h0);

      // Single write: add $8,$9,$10
      drive(1, 32'h012A4020, 32'h00400000, 0, 0);
      cyc();
      drive(0, 32'h0, 32'h0, 0, 0);
      chk("single_out_valid", 64'(bus.out_valid), 64'h1);
      chk("single_out_op",    64'(bus.out_op),    64'h00);
      chk("single_out_func",  64'(bus.out_func),  64'h20);
      chk("single_out_pc",    64'(bus.out_pc),    64'h00400000);
      chk("single_count",     64'(bus.count),     64'h1);
      drive(0, 32'h0, 32'h0, 1, 0);
      cyc();
      chk("drain_count", 64'(bus.count), 64'h0);

      // Fill and backpressure
      drive(1, 32'h8C880004, 32'h00400004, 0, 0);
      cyc();
      drive(1, 32'h2108FFFF, 32'h00400008, 0, 0);
      cyc();
      chk("full_count",    64'(bus.count),    64'h2);
      chk("full_in_ready", 64'(bus.in_ready), 64'h0);
      drive(1, 32'hDEADBEEF, 32'h0040000C, 0, 0);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("stall_head", 64'(bus.out_inst), 64'h8C880004);
         chk("stall_op",   64'(bus.out_op),   64'h23);
         chk("stall_count", 64'(bus.count),   64'h2);
      end

      // Simultaneous read/write at count=1
      drive(0, 32'h0, 32'h0, 1, 0);
      cyc();
      chk("rw_pre_count", 64'(bus.count),    64'h1);
      chk("rw_pre_head",  64'(bus.out_inst), 64'h2108FFFF);
      drive(1, 32'h00851820, 32'h00400010, 1, 0);
      cyc();
      chk("rw_count", 64'(bus.count),    64'h1);
      chk("rw_head",  64'(bus.out_inst), 64'h00851820);
      drive(0, 32'h0, 32'h0, 1, 0);
      cyc();
      chk("rw_drained", 64'(bus.count), 64'h0);

      // Stream 16 random words under random out_ready
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      sent = 0;
      got.delete();
      for (int c = 0; c < 400 && got.size() < 16; c++) begin
         bus.in_valid  = (sent < 16) && ($urandom_range(0, 3) != 0);
         bus.in_inst   = (sent < 16) ? words[sent] : 32'h0;
         bus.in_pc     = 32'h00500000 + 32'(sent * 4);
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.flush     = 1'b0;
         acc_w = bus.in_valid && (mq.size() < DEPTH);
         if (bus.out_ready && mq.size() != 0) got.push_back(bus.out_inst);
         cyc();
         if (acc_w) sent++;
      end
      chk("stream_len", 64'(got.size()), 64'd16);
      for (int i = 0; i < 16; i++)
         if (i < got.size()) chk("stream_order", 64'(got[i]), 64'(words[i]));
      drive(0, 32'h0, 32'h0, 1, 0);
      cyc();

      // Wrap-around: 7 back-to-back transfers
      got.delete();
      for (int i = 0; i < 7; i++) begin
         drive(1, 32'h10000000 + 32'(i), 32'h00600000 + 32'(i * 4), 1, 0);
         if (mq.size() != 0) got.push_back(bus.out_inst);
         cyc();
      end
      drive(0, 32'h0, 32'h0, 1, 0);
      if (mq.size() != 0) got.push_back(bus.out_inst);
      cyc();
      chk("wrap_len", 64'(got.size()), 64'd7);
      for (int i = 0; i < 7; i++)
         if (i < got.size()) chk("wrap_order", 64'(got[i]), 64'(32'h10000000 + 32'(i)));

      // Flush with a concurrent write
      drive(1, 32'hAAAA0001, 32'h00700000, 0, 0);
      cyc();
      drive(1, 32'hAAAA0002, 32'h00700004, 0, 0);
      cyc();
      chk("flush_pre_count", 64'(bus.count), 64'h2);
      drive(1, 32'h08100000, 32'h00700008, 0, 1);
      cyc();
      chk("flush_count",     64'(bus.count),     64'h0);
      chk("flush_out_valid", 64'(bus.out_valid), 64'h0);
      chk("flush_in_ready",  64'(bus.in_ready),  64'h1);
      drive(0, 32'h0, 32'h0, 0, 0);
      cyc();
      chk("flush_discard", 64'(bus.count), 64'h0);

      // Flush together with a read
      drive(1, 32'hBBBB0001, 32'h00800000, 0, 0);
      cyc();
      cyc();
      drive(0, 32'h0, 32'h0, 1, 1);
      cyc();
      chk("flush_rd_count", 64'(bus.count), 64'h0);

      // Asynchronous reset mid-cycle with count=2
      drive(1, 32'hCCCC0001, 32'h00900000, 0, 0);
      cyc();
      drive(1, 32'hCCCC0002, 32'h00900004, 0, 0);
      cyc();
      drive(0, 32'h0, 32'h0, 0, 0);
      chk("arst_pre_count", 64'(bus.count), 64'h2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(bus.out_valid), 64'h0);
      chk("arst_count",     64'(bus.count),     64'h0);
      chk("arst_out_inst",  64'(bus.out_inst),  64'h0);
      chk("arst_out_pc",    64'(bus.out_pc),    64'h0);
      chk("arst_in_ready",  64'(bus.in_ready),  64'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      cyc();

      // Random traffic, occasional flush
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0));
         cyc();
      end
      drive(0, 32'h0, 32'h0, 0, 0);
      cyc();
      @(negedge clk);
      #1 run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
